bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative double-dabble (one shift per clock). It is the reverse of the BCD-to-binary path.
- Takes the ALU's binary result (two's complement by default) and produces packed BCD digits plus sign and overflow flags for the result formatter and display mux.
- Start/done handshake. Replaces wide combinational conversion on the result path.

---
 rtl/bin_to_bcd_seq.sv | 139 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Iterative double-dabble binary-to-BCD converter, one shift per clock.
// Revision : 1.0
// ============================================================================
module bin_to_bcd_seq #(
  parameter int WIDTH  = 21,
  parameter int DIGITS = 8,
  parameter int SIGNED = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg_out,
  output logic                  ovf_out
);

  localparam int C_BCD_W = 4 * DIGITS;
  localparam int C_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_finish;

  logic [WIDTH-1:0]     r_mag;
  logic [C_BCD_W-1:0]   r_scratch;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_sign;
  logic                 r_nz;
  logic                 r_ovf_acc;
  logic                 r_done;
  logic [C_BCD_W-1:0]   r_bcd;
  logic                 r_neg;
  logic                 r_ovf;

  logic                 w_neg_in;
  logic [WIDTH-1:0]     w_mag_in;
  logic [C_BCD_W-1:0]   w_adj;

  // Most negative input negates to 2^(WIDTH-1), which still fits unsigned.
  assign w_neg_in = (SIGNED != 0) && bin_in[WIDTH-1];
  assign w_mag_in = w_neg_in ? (~bin_in + WIDTH'(1)) : bin_in;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                (r_scratch[4*gi +: 4] + 4'd3) :
                                r_scratch[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CONVERT;
        end
      end
      S_CONVERT: begin
        w_shift = 1'b1;
        if (r_cnt == C_CNT_W'(WIDTH - 1)) w_state_nxt = S_FINISH;
      end
      S_FINISH: begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mag     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_nz      <= 1'b0;
      r_ovf_acc <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_mag     <= w_mag_in;
        r_sign    <= w_neg_in;
        r_nz      <= |w_mag_in;
        r_scratch <= '0;
        r_ovf_acc <= 1'b0;
        r_cnt     <= '0;
      end
      if (w_shift) begin
        // Any bit leaving the top digit means the value needs more digits.
        r_scratch <= {w_adj[C_BCD_W-2:0], r_mag[WIDTH-1]};
        r_mag     <= {r_mag[WIDTH-2:0], 1'b0};
        r_ovf_acc <= r_ovf_acc | w_adj[C_BCD_W-1];
        r_cnt     <= r_cnt + C_CNT_W'(1);
      end
      if (w_finish) begin
        r_bcd <= r_scratch;
        r_neg <= r_sign & r_nz;
        r_ovf <= r_ovf_acc;
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign bcd_out = r_bcd;
  assign neg_out = r_neg;
  assign ovf_out = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Purpose  : Bench for bin_to_bcd_seq in signed, unsigned and 4-digit builds.
// Revision : 1.0
// ============================================================================
module tb_bin_to_bcd_seq;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [20:0] bin_in;

  logic        busy_s, done_s, neg_s, ovf_s;
  logic [31:0] bcd_s;
  logic        busy_u, done_u, neg_u, ovf_u;
  logic [31:0] bcd_u;
  logic        busy_d, done_d, neg_d, ovf_d;
  logic [15:0] bcd_d;

  int n_tests = 0;
  int n_fail  = 0;

  bin_to_bcd_seq #(.WIDTH(21), .DIGITS(8), .SIGNED(1)) u_s (
    .clock(clock), .reset_n(reset_n), .start(start), .bin_in(bin_in),
    .busy(busy_s), .done(done_s), .bcd_out(bcd_s), .neg_out(neg_s), .ovf_out(ovf_s));

  bin_to_bcd_seq #(.WIDTH(21), .DIGITS(8), .SIGNED(0)) u_u (
    .clock(clock), .reset_n(reset_n), .start(start), .bin_in(bin_in),
    .busy(busy_u), .done(done_u), .bcd_out(bcd_u), .neg_out(neg_u), .ovf_out(ovf_u));

  bin_to_bcd_seq #(.WIDTH(21), .DIGITS(4), .SIGNED(1)) u_d (
    .clock(clock), .reset_n(reset_n), .start(start), .bin_in(bin_in),
    .busy(busy_d), .done(done_d), .bcd_out(bcd_d), .neg_out(neg_d), .ovf_out(ovf_d));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: plain arithmetic on the numeric value.
  function automatic void model(input logic [20:0] raw, input bit sgn, input int nd,
                                output longint bcd, output bit neg, output bit ovf);
    longint v, m, lim, t;
    v   = longint'(raw);
    m   = v;
    neg = 1'b0;
    if (sgn && v >= (64'd1 << 20)) begin
      m   = (64'd1 << 21) - v;
      neg = (m != 0);
    end
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ovf = (m >= lim);
    t   = m % lim;
    bcd = 0;
    for (int i = 0; i < nd; i++) begin
      bcd = bcd | ((t % 10) << (4 * i));
      t   = t / 10;
    end
  endfunction

  task automatic check_outputs(input logic [20:0] v);
    longint eb; bit en, eo;
    chk("done_u", 64'(done_u), 64'd1);
    chk("done_d", 64'(done_d), 64'd1);
    model(v, 1'b1, 8, eb, en, eo);
    chk("bcd_s", 64'(bcd_s), eb); chk("neg_s", 64'(neg_s), 64'(en)); chk("ovf_s", 64'(ovf_s), 64'(eo));
    model(v, 1'b0, 8, eb, en, eo);
    chk("bcd_u", 64'(bcd_u), eb); chk("neg_u", 64'(neg_u), 64'(en)); chk("ovf_u", 64'(ovf_u), 64'(eo));
    model(v, 1'b1, 4, eb, en, eo);
    chk("bcd_d", 64'(bcd_d), eb); chk("neg_d", 64'(neg_d), 64'(en)); chk("ovf_d", 64'(ovf_d), 64'(eo));
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); @(negedge clock);
      if (done_s) begin
        lat = k;
        break;
      end
      if (busy_s) bcnt++;
    end
  endtask

  task automatic launch(input logic [20:0] v);
    bin_in = v;
    start  = 1'b1;
    @(posedge clock); @(negedge clock);
    start  = 1'b0;
    bin_in = 21'($urandom);
    chk("busy_accept", 64'(busy_s), 64'd1);
  endtask

  task automatic convert(input logic [20:0] v);
    int lat, bcnt;
    launch(v);
    wait_done(lat, bcnt);
    chk("latency", 64'(lat), 64'd22);
    chk("busy_cycles", 64'(bcnt), 64'd21);
    chk("busy_at_done", 64'(busy_s), 64'd0);
    check_outputs(v);
    @(negedge clock);
    chk("done_pulse", 64'(done_s), 64'd0);
  endtask

  int          dir [8] = '{0, 'h0FFFFF, 'h1FFFFF, 'h100000, 12345, 9999, 37, 1};
  int          lat, bcnt, ndone, k_done;
  logic [20:0] rv;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    bin_in  = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy_s), 64'd0);
    chk("rst_done", 64'(done_s), 64'd0);
    chk("rst_bcd",  64'(bcd_s),  64'd0);
    chk("rst_neg",  64'(neg_s),  64'd0);
    chk("rst_ovf",  64'(ovf_s),  64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    foreach (dir[i]) begin
      convert(21'(dir[i]));
      if (dir[i] == 'h0FFFFF) chk("plan_0fffff", 64'(bcd_s), 64'h01048575);
      if (dir[i] == 'h100000) chk("plan_100000", 64'({neg_s, bcd_s}), 64'h1_01048576);
    end

    for (int i = 0; i < 16; i++) begin
      rv = 21'($urandom);
      convert(rv);
    end

    // Re-pulsed start while busy must be ignored; start in the done cycle accepted.
    launch(21'd37);
    ndone  = 0;
    k_done = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5 || k == 10) begin
        bin_in = 21'd99;
        start  = 1'b1;
      end else begin
        start  = 1'b0;
      end
      @(posedge clock); @(negedge clock);
      if (done_s) begin
        ndone  = ndone + 1;
        k_done = k;
        break;
      end
    end
    start = 1'b0;
    chk("ignore_done", 64'(ndone), 64'd1);
    chk("ignore_lat", 64'(k_done), 64'd22);
    chk("ignore_bcd", 64'(bcd_s), 64'h00000037);
    launch(21'd500);
    chk("hold_bcd", 64'(bcd_s), 64'h00000037);
    wait_done(lat, bcnt);
    chk("b2b_lat", 64'(lat), 64'd22);
    check_outputs(21'd500);
    chk("b2b_bcd", 64'(bcd_s), 64'h00000500);
    @(negedge clock);

    // Asynchronous abort mid-conversion.
    launch(21'd123456);
    repeat (9) begin
      @(posedge clock); @(negedge clock);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_s), 64'd0);
    chk("abort_done", 64'(done_s), 64'd0);
    chk("abort_bcd",  64'(bcd_s),  64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); @(negedge clock);
      if (done_s) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    convert(21'd123456);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
